// File: rtl/reg_bank_core.sv
// reg_bank_core: register storage with a handshaked write port and a sequential bulk clear
module reg_bank_core #(
  parameter int N = 32,
  parameter int Bits = 64
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [$clog2(N)-1:0] write_code,
  input  logic [Bits-1:0]      wr_data,
  input  logic                 clear_req,
  output logic [Bits-1:0]      D [N],
  output logic [N-1:0]         written,
  output logic                 busy
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state, state_nx;
  logic [W-1:0] clr_idx, clr_idx_nx;
  logic last, wr_fire;
  assign busy = state == CLEAR;
  assign last = clr_idx == LAST;
  assign wr_ready = !busy && !clear_req;
  assign wr_fire = wr_valid && wr_ready && int'(write_code) < N;
  always_comb begin
    state_nx = busy ? (last ? IDLE : CLEAR) : (clear_req ? CLEAR : IDLE);
    clr_idx_nx = (busy && !last) ? clr_idx + W'(1) : '0;
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      state <= IDLE;
      clr_idx <= '0;
      written <= '0;
      for (int j = 0; j < N; j++) D[j] <= '0;
    end else begin
      state <= state_nx;
      clr_idx <= clr_idx_nx;
      if (busy) begin
        D[clr_idx] <= '0;
        written[clr_idx] <= 1'b0;
      end else if (wr_fire) begin
        D[write_code] <= wr_data;
        written[write_code] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_reg_bank_core.sv
// tb_reg_bank_core: directed checks of reg_bank_core against a behavioural bank model
module tb_reg_bank_core;
  logic clk = 0, reset_L = 0;
  always #5 clk = ~clk;
  logic a_vld = 0, a_clr = 0, a_ready, a_busy;
  logic [4:0] a_code = '0;
  logic [63:0] a_data = '0;
  logic [63:0] a_d [32];
  logic [31:0] a_written;
  logic b_vld = 0, b_clr = 0, b_ready, b_busy;
  logic [2:0] b_code = '0;
  logic [63:0] b_data = '0;
  logic [63:0] b_d [5];
  logic [4:0] b_written;
  int n_chk = 0, n_fail = 0;
  reg_bank_core #(.N(32), .Bits(64)) dut_a (
    .clk(clk), .reset_L(reset_L), .wr_valid(a_vld), .wr_ready(a_ready),
    .write_code(a_code), .wr_data(a_data), .clear_req(a_clr),
    .D(a_d), .written(a_written), .busy(a_busy));
  reg_bank_core #(.N(5), .Bits(64)) dut_b (
    .clk(clk), .reset_L(reset_L), .wr_valid(b_vld), .wr_ready(b_ready),
    .write_code(b_code), .wr_data(b_data), .clear_req(b_clr),
    .D(b_d), .written(b_written), .busy(b_busy));
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  logic [63:0] m_d [32];
  logic [31:0] m_w;
  bit m_clearing;
  int m_next;
  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_d[i] = '0;
    m_w = '0;
    m_clearing = 0;
    m_next = 0;
  endtask
  initial m_reset();
  always @(negedge reset_L) m_reset();
  always @(posedge clk)
    if (!reset_L) m_reset();
    else if (m_clearing) begin
      m_d[m_next] = '0;
      m_w[m_next] = 1'b0;
      m_next++;
      if (m_next == 32) m_clearing = 0;
    end else if (a_clr) begin
      m_clearing = 1;
      m_next = 0;
    end else if (a_vld) begin
      m_d[a_code] = a_data;
      m_w[a_code] = 1'b1;
    end
  always @(negedge clk) begin
    for (int i = 0; i < 32; i++) chk($sformatf("model D[%0d]", i), a_d[i], m_d[i]);
    chk("model written", 64'(a_written), 64'(m_w));
    chk("model busy", 64'(a_busy), 64'(m_clearing));
    chk("model wr_ready", 64'(a_ready), 64'(!m_clearing && !a_clr));
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  int k;
  initial begin
    @(posedge clk);
    #2;
    chk("rst busy", 64'(a_busy), 0);
    chk("rst written", 64'(a_written), 0);
    chk("rst D[6]", a_d[6], 0);
    chk("rst wr_ready", 64'(a_ready), 1);
    @(negedge clk) reset_L = 1;
    step();
    chk("post-rst wr_ready", 64'(a_ready), 1);
    a_vld = 1; a_code = 6; a_data = 64'd32;
    step();
    chk("wr1 D[6]", a_d[6], 64'd32);
    a_data = 64'd30;
    step();
    chk("wr2 D[6]", a_d[6], 64'd30);
    chk("wr2 written", 64'(a_written), 64'h40);
    chk("wr2 D[7]", a_d[7], 0);
    a_code = 2; a_data = 64'd6;
    step();
    a_code = 3; a_data = 64'd9;
    step();
    a_vld = 0;
    chk("b2b D[2]", a_d[2], 64'd6);
    chk("b2b D[3]", a_d[3], 64'd9);
    chk("b2b written", 64'(a_written), 64'h4C);
    a_clr = 1; a_vld = 1; a_code = 5; a_data = 64'd7;
    #1;
    chk("clr req wr_ready", 64'(a_ready), 0);
    step();
    a_clr = 0;
    chk("clr t0 busy", 64'(a_busy), 1);
    chk("clr t0 D[5]", a_d[5], 0);
    k = 0;
    while (a_busy && k < 100) begin
      step();
      k++;
      if (k == 3) begin
        chk("clr t3 D[2]", a_d[2], 0);
        chk("clr t3 D[3]", a_d[3], 64'd9);
      end
    end
    chk("clr busy cycles", 64'(k), 32);
    chk("clr written", 64'(a_written), 0);
    chk("clr D[6]", a_d[6], 0);
    chk("clr D[5]", a_d[5], 0);
    chk("clr end wr_ready", 64'(a_ready), 1);
    step();
    a_vld = 0;
    chk("post-clr D[5]", a_d[5], 64'd7);
    chk("post-clr written", 64'(a_written), 64'h20);
    a_vld = 1; a_code = 20; a_data = 64'hABCD;
    step();
    a_vld = 0; a_clr = 1;
    step();
    a_clr = 0;
    repeat (9) step();
    chk("mid-clr busy", 64'(a_busy), 1);
    chk("mid-clr D[20]", a_d[20], 64'hABCD);
    #2 reset_L = 0;
    #1;
    chk("async rst busy", 64'(a_busy), 0);
    chk("async rst D[20]", a_d[20], 0);
    chk("async rst written", 64'(a_written), 0);
    chk("async rst wr_ready", 64'(a_ready), 1);
    @(negedge clk) reset_L = 1;
    step();
    chk("rst release busy", 64'(a_busy), 0);
    a_vld = 1; a_code = 1; a_data = 64'd5;
    step();
    a_vld = 0;
    chk("rst release D[1]", a_d[1], 64'd5);
    b_vld = 1; b_code = 6; b_data = 64'd1;
    #1;
    chk("n5 oob wr_ready", 64'(b_ready), 1);
    step();
    chk("n5 oob written", 64'(b_written), 0);
    for (int i = 0; i < 5; i++) chk($sformatf("n5 oob D[%0d]", i), b_d[i], 0);
    b_code = 4; b_data = 64'd3;
    step();
    b_vld = 0;
    chk("n5 last D[4]", b_d[4], 64'd3);
    chk("n5 last written", 64'(b_written), 64'h10);
    b_clr = 1;
    step();
    b_clr = 0;
    k = 0;
    while (b_busy && k < 100) begin
      step();
      k++;
    end
    chk("n5 clr busy cycles", 64'(k), 5);
    chk("n5 clr written", 64'(b_written), 0);
    chk("n5 clr D[4]", b_d[4], 0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
